// File: rtl/fixed_multiplier.sv
// Sequential signed Q8.8 fixed-point multiplier.
// Shift-add over operand magnitudes (one partial product per clock), then sign fix-up,
// saturation toward the representable range and a registered result with a done pulse.
module fixed_multiplier #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] Multiplicand,
  input  logic [WIDTH-1:0] Multiplier,
  output logic [WIDTH-1:0] Product,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MaxNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [WIDTH-1:0]    r_mcand;
  logic [WIDTH-1:0]    r_mplr;
  logic                r_sign;
  logic [2*WIDTH-1:0]  r_acc;
  logic [CntW-1:0]     r_cnt;
  logic [WIDTH-1:0]    r_product;
  logic                r_error;
  logic                r_done;

  logic [WIDTH-1:0]    w_abs_a;
  logic [WIDTH-1:0]    w_abs_b;
  logic [2*WIDTH-1:0]  w_addend;
  logic [WIDTH-1:0]    w_mag;
  logic                w_ovf;
  logic [WIDTH-1:0]    w_result;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    w_abs_a = Multiplicand[WIDTH-1] ? (~Multiplicand + 1'b1) : Multiplicand;
    w_abs_b = Multiplier[WIDTH-1]   ? (~Multiplier + 1'b1)   : Multiplier;
    w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  end

  // Truncate the magnitude (round toward zero), then saturate and re-apply the sign.
  always_comb begin
    w_mag = r_acc[WIDTH+FRAC-1:FRAC];
    w_ovf = (|r_acc[2*WIDTH-1:WIDTH+FRAC]) ||
            (!r_sign && (w_mag > MaxPos)) ||
            (r_sign && (w_mag > MaxNeg));
    if (w_ovf) begin
      w_result = r_sign ? MaxNeg : MaxPos;
    end else begin
      w_result = r_sign ? (~w_mag + 1'b1) : w_mag;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and busy decode.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_next = StCalc;
        end
      end
      StCalc: begin
        busy = 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        busy         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: operand capture, shift-add iterations and result registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_sign    <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_error   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // done is registered on leaving DONE so it coincides with the new Product.
      r_done <= (r_state == StDone);
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_mcand <= w_abs_a;
            r_mplr  <= w_abs_b;
            r_sign  <= Multiplicand[WIDTH-1] ^ Multiplier[WIDTH-1];
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        StCalc: begin
          if (r_mplr[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_mplr <= r_mplr >> 1;
          r_cnt  <= r_cnt + 1'b1;
        end
        StDone: begin
          r_product <= w_result;
          r_error   <= w_ovf;
        end
        default: ;
      endcase
    end
  end

  assign Product = r_product;
  assign error   = r_error;
  assign done    = r_done;

endmodule

// File: tb/tb_fixed_multiplier.sv
// Self-checking bench for fixed_multiplier: directed vectors with literal expectations
// plus a saturating real-arithmetic model checked against the DUT on every cycle.
module tb_fixed_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] Multiplicand;
  logic [15:0] Multiplier;
  logic [15:0] Product;
  logic        busy;
  logic        done;
  logic        error;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    int          acc_cyc;
    logic [15:0] a;
    logic [15:0] b;
  } op_t;

  op_t         q[$];
  logic [15:0] last_p;
  logic        last_e;

  fixed_multiplier #(.WIDTH(16), .FRAC(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .Multiplicand (Multiplicand),
    .Multiplier   (Multiplier),
    .Product      (Product),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Ideal model: exact signed product, magnitude truncated, then clamped to 16 bits.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] p, output logic e);
    longint sa, sb, prod, mag, r;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    prod = sa * sb;
    mag  = (prod < 0) ? -prod : prod;
    mag  = mag / 256;
    r    = (prod < 0) ? -mag : mag;
    if (r > 32767) begin
      p = 16'h7FFF; e = 1'b1;
    end else if (r < -32768) begin
      p = 16'h8000; e = 1'b1;
    end else begin
      p = r[15:0]; e = 1'b0;
    end
  endfunction

  // Per-cycle checker: reset values, busy window, exact done cycle, held result.
  always @(negedge clk) begin
    logic exp_done, exp_busy, mp_e;
    logic [15:0] mp_p;
    if (rst) begin
      n_cmp++;
      if (Product !== 16'h0 || error !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: got P=%h e=%b busy=%b done=%b, want all zero",
                 Product, error, busy, done);
      end
      last_p = 16'h0;
      last_e = 1'b0;
    end else begin
      exp_done = (q.size() > 0) && (cyc == q[0].acc_cyc + 17);
      exp_busy = (q.size() > 0) && (cyc >= q[0].acc_cyc) && (cyc <= q[0].acc_cyc + 16);
      n_cmp++;
      if (done !== exp_done) begin
        n_fail++;
        $display("FAIL done_timing: cyc=%0d got done=%b want %b", cyc, done, exp_done);
      end
      n_cmp++;
      if (busy !== exp_busy) begin
        n_fail++;
        $display("FAIL busy: cyc=%0d got busy=%b want %b", cyc, busy, exp_busy);
      end
      if (exp_done) begin
        model(q[0].a, q[0].b, mp_p, mp_e);
        last_p = mp_p;
        last_e = mp_e;
        void'(q.pop_front());
      end
      n_cmp++;
      if (Product !== last_p || error !== last_e) begin
        n_fail++;
        $display("FAIL result_model: cyc=%0d got P=%h e=%b want P=%h e=%b",
                 cyc, Product, error, last_p, last_e);
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    op_t op;
    Multiplicand = a;
    Multiplier   = b;
    start        = 1'b1;
    op.acc_cyc   = cyc + 1;
    op.a         = a;
    op.b         = b;
    q.push_back(op);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_fail++;
      $display("FAIL done_timeout: got no done within 40 cycles, want a done pulse");
    end
  endtask

  task automatic check_lit(input string name, input logic [15:0] want_p, input logic want_e);
    n_cmp++;
    if (Product !== want_p || error !== want_e) begin
      n_fail++;
      $display("FAIL %s: got P=%h e=%b want P=%h e=%b", name, Product, error, want_p, want_e);
    end
  endtask

  // Directed op: pins the model against the literal, then the DUT against the literal.
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] want_p, input logic want_e);
    logic ok, me;
    logic [15:0] mp;
    model(a, b, mp, me);
    n_cmp++;
    if (mp !== want_p || me !== want_e) begin
      n_fail++;
      $display("FAIL model_%s: got P=%h e=%b want P=%h e=%b", name, mp, me, want_p, want_e);
    end
    issue(a, b);
    wait_done(ok);
    if (ok) check_lit(name, want_p, want_e);
  endtask

  initial begin
    logic ok;
    logic [15:0] ra, rb;
    rst          = 1'b0;
    start        = 1'b0;
    Multiplicand = 16'h0;
    Multiplier   = 16'h0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    check_lit("reset_product", 16'h0000, 1'b0);
    @(posedge clk);
    #2;

    do_op("mul_2x3",       16'h0200, 16'h0300, 16'h0600, 1'b0);
    do_op("mul_m1p5x2",    16'hFE80, 16'h0200, 16'hFD00, 1'b0);
    do_op("mul_half_half", 16'h0080, 16'h0080, 16'h0040, 1'b0);
    do_op("sat_pos",       16'h6400, 16'h6400, 16'h7FFF, 1'b1);
    do_op("sat_neg",       16'h9C00, 16'h6400, 16'h8000, 1'b1);
    do_op("min_x1",        16'h8000, 16'h0100, 16'h8000, 1'b0);
    do_op("min_xm1",       16'h8000, 16'hFF00, 16'h7FFF, 1'b1);
    do_op("toward_zero",   16'hFFFF, 16'h0080, 16'h0000, 1'b0);
    do_op("zero_operand",  16'h0000, 16'h8123, 16'h0000, 1'b0);

    // Start during CALC with new operands must be ignored.
    issue(16'h0200, 16'h0300);
    repeat (5) @(posedge clk);
    #2;
    Multiplicand = 16'h1234;
    Multiplier   = 16'h0456;
    start        = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(ok);
    if (ok) check_lit("ignore_busy_start", 16'h0600, 1'b0);
    // Start raised in the done cycle is accepted on the next edge.
    issue(16'h0080, 16'h0080);
    wait_done(ok);
    if (ok) check_lit("back_to_back", 16'h0040, 1'b0);

    // Reset in mid-CALC aborts without a done pulse.
    @(posedge clk);
    #2;
    issue(16'h0300, 16'h0200);
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check_lit("abort_product", 16'h0000, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    do_op("after_abort", 16'h0180, 16'h0200, 16'h0300, 1'b0);

    // Random operands, alternating full-range and small-magnitude multipliers.
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i[0]) rb = {{6{rb[9]}}, rb[9:0]};
      issue(ra, rb);
      wait_done(ok);
      if (($urandom % 2) == 0) begin
        @(posedge clk);
        #2;
      end
    end
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
